seg7_scan: RTL and testbench

- Multiplexed multi-digit 7-segment driver; successor to the single-digit combinational hex-to-segment decoder.
- Holds a shadow copy of DIGITS hex nibbles, decimal points and per-digit blanks, and scans one digit at a time.
- Drives a shared segment bus plus one-hot digit enables, with guard (dead) time between digits to prevent ghosting.
- Sits between the top-level display register file and the board's segment/anode pins.

---
 rtl/seg7_scan_if.sv | 35 +++
 rtl/seg7_scan.sv | 172 +++++++++++++++++
 tb/tb_seg7_scan.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_if
// Purpose : bundles the display register-file side (digit data, decimal
//           points, blanks, load request) and the pin side (segment bus,
//           digit enables, frame pulse) of the multiplexed 7-segment driver.
// Signals : iDATA  [4*DIGITS] hex nibbles, digit 0 least significant
//           iDP    [DIGITS]   decimal point per digit, 1 = lit
//           iBLANK [DIGITS]   1 = digit dark for its whole slot
//           iLOAD             request shadow update at next frame start
//           oSEG   [8]        active-high segments, [7:1] pattern, [0] dp
//           oDIG   [DIGITS]   one-hot active-high digit enable
//           oFRAME            one-cycle pulse when digit 0's slot begins
// Modports: master = register file / testbench, slave = seg7_scan.
// ---------------------------------------------------------------------------
interface seg7_scan_if #(
   parameter int DIGITS = 8
);
   logic [4*DIGITS-1:0] iDATA;
   logic [DIGITS-1:0]   iDP;
   logic [DIGITS-1:0]   iBLANK;
   logic                iLOAD;
   logic [7:0]          oSEG;
   logic [DIGITS-1:0]   oDIG;
   logic                oFRAME;

   modport master (
      output iDATA, iDP, iBLANK, iLOAD,
      input  oSEG, oDIG, oFRAME
   );

   modport slave (
      input  iDATA, iDP, iBLANK, iLOAD,
      output oSEG, oDIG, oFRAME
   );
endinterface

// File: rtl/seg7_scan.sv
// ---------------------------------------------------------------------------
// seg7_scan
// Purpose : multiplexed multi-digit 7-segment driver. A shadow copy of the
//           digit nibbles, decimal points and blanks is captured only at
//           frame start, so a frame never mixes old and new data. Each digit
//           owns a slot of CLK_DIV cycles whose first GUARD cycles are dead
//           (all outputs off) to avoid ghosting between digits.
// Ports   : iCLK  system clock
//           iRST  asynchronous active-high reset
//           bus   seg7_scan_if.slave (iDATA, iDP, iBLANK, iLOAD in;
//                 oSEG, oDIG, oFRAME out, all registered)
// Options : define SEG7_LEADING_ZERO_EN to blank leading zero digits
//           (decimal points of suppressed digits still light).
// ---------------------------------------------------------------------------
module seg7_scan #(
   parameter int DIGITS  = 8,
   parameter int CLK_DIV = 50000,
   parameter int GUARD   = 16
) (
   input logic       iCLK,
   input logic       iRST,
   seg7_scan_if.slave bus
);

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [PW-1:0]       presc;
   logic [IW-1:0]       index;
   logic                pending;
   logic [4*DIGITS-1:0] sh_data;
   logic [DIGITS-1:0]   sh_dp;
   logic [DIGITS-1:0]   sh_blank;
   logic [7:0]          seg_q;
   logic [DIGITS-1:0]   dig_q;
   logic                frame_q;

   logic                frame_start;
   logic                capture;
   logic                in_guard;
   logic [4*DIGITS-1:0] nx_data;
   logic [DIGITS-1:0]   nx_dp;
   logic [DIGITS-1:0]   nx_blank;
   logic [3:0]          nibble;
   logic [7:0]          seg_n;
   logic [DIGITS-1:0]   dig_n;

`ifdef SEG7_LEADING_ZERO_EN
   logic [DIGITS-1:0]   sh_supp;
   logic [DIGITS-1:0]   cap_supp;
   logic [DIGITS-1:0]   nx_supp;
   logic                above_ok;
`endif

   function automatic logic [6:0] pattern(input logic [3:0] n);
      case (n)
         4'h0:    pattern = 7'b0111111;
         4'h1:    pattern = 7'b0001001;
         4'h2:    pattern = 7'b1011110;
         4'h3:    pattern = 7'b1011011;
         4'h4:    pattern = 7'b1101001;
         4'h5:    pattern = 7'b1110011;
         4'h6:    pattern = 7'b1110111;
         4'h7:    pattern = 7'b0011001;
         4'h8:    pattern = 7'b1111111;
         4'h9:    pattern = 7'b1111001;
         4'hA:    pattern = 7'b1111101;
         4'hB:    pattern = 7'b1100111;
         4'hC:    pattern = 7'b0110110;
         4'hD:    pattern = 7'b1001111;
         4'hE:    pattern = 7'b1110110;
         default: pattern = 7'b1110100;
      endcase
   endfunction

`ifdef SEG7_LEADING_ZERO_EN
   // Walk from the most significant digit down: a zero digit is suppressed
   // while everything above it is zero or blank. Digit 0 is never suppressed.
   always_comb begin
      above_ok = 1'b1;
      cap_supp = '0;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         if (bus.iDATA[4*k +: 4] == 4'h0 && above_ok)
            cap_supp[k] = 1'b1;
         above_ok = above_ok && (bus.iDATA[4*k +: 4] == 4'h0 || bus.iBLANK[k]);
      end
   end
`endif

   // The output registers are loaded from the values the shadow will hold
   // after this edge, so the first slot of a new frame already shows the
   // freshly captured data even when there is no guard time.
   always_comb begin
      frame_start = (presc == '0) && (index == '0);
      capture     = frame_start && (pending || bus.iLOAD);
      nx_data     = capture ? bus.iDATA  : sh_data;
      nx_dp       = capture ? bus.iDP    : sh_dp;
      nx_blank    = capture ? bus.iBLANK : sh_blank;
`ifdef SEG7_LEADING_ZERO_EN
      nx_supp     = capture ? cap_supp   : sh_supp;
`endif
      in_guard    = int'(presc) < GUARD;
      nibble      = nx_data[4*int'(index) +: 4];
      seg_n       = '0;
      dig_n       = '0;
      if (!in_guard) begin
         if (nx_blank[index]) begin
            seg_n = '0;
`ifdef SEG7_LEADING_ZERO_EN
         end else if (nx_supp[index]) begin
            if (nx_dp[index]) begin
               dig_n[index] = 1'b1;
               seg_n        = 8'h01;
            end
`endif
         end else begin
            dig_n[index] = 1'b1;
            seg_n        = {pattern(nibble), nx_dp[index]};
         end
      end
   end

   // Prescaler/index scanning, load-request bookkeeping, shadow capture and
   // the registered outputs. Reset leaves a load pending so the first frame
   // after reset always captures the inputs.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         presc    <= '0;
         index    <= '0;
         pending  <= 1'b1;
         sh_data  <= '0;
         sh_dp    <= '0;
         sh_blank <= '0;
`ifdef SEG7_LEADING_ZERO_EN
         sh_supp  <= '0;
`endif
         seg_q    <= '0;
         dig_q    <= '0;
         frame_q  <= 1'b0;
      end else begin
         if (int'(presc) == CLK_DIV - 1) begin
            presc <= '0;
            index <= (int'(index) == DIGITS - 1) ? '0 : index + 1'b1;
         end else begin
            presc <= presc + 1'b1;
         end

         if (frame_start)
            pending <= 1'b0;
         else if (bus.iLOAD)
            pending <= 1'b1;

         if (capture) begin
            sh_data  <= bus.iDATA;
            sh_dp    <= bus.iDP;
            sh_blank <= bus.iBLANK;
`ifdef SEG7_LEADING_ZERO_EN
            sh_supp  <= cap_supp;
`endif
         end

         seg_q   <= seg_n;
         dig_q   <= dig_n;
         frame_q <= frame_start;
      end
   end

   assign bus.oSEG   = seg_q;
   assign bus.oDIG   = dig_q;
   assign bus.oFRAME = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan
// Purpose : scoreboard testbench for seg7_scan (DIGITS=4, CLK_DIV=8,
//           GUARD=2). A reference model derives the expected outputs from
//           elapsed cycles since reset (frame position arithmetic) and pushes
//           them into a queue; a monitor pops one entry per cycle and
//           compares. Honours SEG7_LEADING_ZERO_EN when defined.
// ---------------------------------------------------------------------------
module tb_seg7_scan;

   localparam int DIGITS  = 4;
   localparam int CLK_DIV = 8;
   localparam int GUARD   = 2;
   localparam int FRAME   = DIGITS * CLK_DIV;

   localparam logic [6:0] PAT [16] = '{
      7'b0111111, 7'b0001001, 7'b1011110, 7'b1011011,
      7'b1101001, 7'b1110011, 7'b1110111, 7'b0011001,
      7'b1111111, 7'b1111001, 7'b1111101, 7'b1100111,
      7'b0110110, 7'b1001111, 7'b1110110, 7'b1110100
   };

   typedef struct packed {
      logic [7:0]        seg;
      logic [DIGITS-1:0] dig;
      logic              frame;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   seg7_scan_if #(.DIGITS(DIGITS)) bus ();

   seg7_scan #(
      .DIGITS (DIGITS),
      .CLK_DIV(CLK_DIV),
      .GUARD  (GUARD)
   ) dut (
      .iCLK(clk),
      .iRST(rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   exp_t expq[$];

   // Reference model state: cycles since reset release plus the frame shadow.
   int          t;
   logic        pend;
   logic [15:0] m_data;
   logic [3:0]  m_dp;
   logic [3:0]  m_blank;

   function automatic int nib(input logic [15:0] d, input int k);
      return int'((d >> (4 * k)) & 16'hF);
   endfunction

   function automatic bit suppressed(input int k);
`ifdef SEG7_LEADING_ZERO_EN
      if (k == 0 || nib(m_data, k) != 0) return 1'b0;
      for (int j = k + 1; j < DIGITS; j++)
         if (nib(m_data, j) != 0 && !m_blank[j]) return 1'b0;
      return 1'b1;
`else
      return (k < 0);
`endif
   endfunction

   // Expected outputs after each rising edge, from the frame position.
   always @(posedge clk) begin
      exp_t e;
      int pos, k, p;
      e = '0;
      if (rst) begin
         t       = 0;
         pend    = 1'b1;
         m_data  = '0;
         m_dp    = '0;
         m_blank = '0;
      end else begin
         pos = t % FRAME;
         k   = pos / CLK_DIV;
         p   = pos % CLK_DIV;
         if (pos == 0) begin
            if (pend || bus.iLOAD) begin
               m_data  = bus.iDATA;
               m_dp    = bus.iDP;
               m_blank = bus.iBLANK;
            end
            pend = 1'b0;
         end else if (bus.iLOAD) begin
            pend = 1'b1;
         end
         e.frame = (pos == 0);
         if (p >= GUARD && !m_blank[k]) begin
            if (suppressed(k)) begin
               if (m_dp[k]) begin
                  e.dig = DIGITS'(1) << k;
                  e.seg = 8'h01;
               end
            end else begin
               e.dig = DIGITS'(1) << k;
               e.seg = {PAT[nib(m_data, k)], m_dp[k]};
            end
         end
         t++;
      end
      expq.push_back(e);
   end

   task automatic checkOutput(input exp_t e, input string name);
      checks++;
      if (bus.oSEG !== e.seg || bus.oDIG !== e.dig || bus.oFRAME !== e.frame) begin
         errors++;
         $display("[TB] FAIL %s t=%0t: got seg=%b dig=%b frame=%b, expected seg=%b dig=%b frame=%b",
                  name, $time, bus.oSEG, bus.oDIG, bus.oFRAME, e.seg, e.dig, e.frame);
      end
   endtask

   // Monitor: one expected entry per cycle, compared just after the edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (expq.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard_empty t=%0t: got empty queue, expected an entry", $time);
      end else begin
         e = expq.pop_front();
         checkOutput(e, "scan");
      end
      checks++;
      if (!$onehot0(bus.oDIG)) begin
         errors++;
         $display("[TB] FAIL dig_onehot t=%0t: got oDIG=%b, expected at most one bit", $time, bus.oDIG);
      end
   end

   task automatic applyStimulus(input logic [15:0] data, input logic [3:0] dp,
                                input logic [3:0] blank, input logic load,
                                input int cycles);
      @(negedge clk);
      bus.iDATA  = data;
      bus.iDP    = dp;
      bus.iBLANK = blank;
      bus.iLOAD  = load;
      @(negedge clk);
      bus.iLOAD  = 1'b0;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic waitFrame(input int budget);
      int n = 0;
      @(negedge clk);
      while (!bus.oFRAME && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!bus.oFRAME) begin
         errors++;
         $display("[TB] FAIL wait_frame: got no oFRAME within %0d cycles, expected a pulse", budget);
      end
   endtask

   initial begin
      bus.iDATA  = 16'h1234;
      bus.iDP    = '0;
      bus.iBLANK = '0;
      bus.iLOAD  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Initial capture of 1234 and steady scanning.
      applyStimulus(16'h1234, 4'b0000, 4'b0000, 1'b0, 3 * FRAME);
      // New data without a load request must not show.
      applyStimulus(16'hABCD, 4'b0000, 4'b0000, 1'b0, 3 * FRAME + 5);
      // Mid-frame load request: new data only from the next frame.
      applyStimulus(16'hABCD, 4'b0000, 4'b0000, 1'b1, 2 * FRAME);
      // Blank digit 2, decimal point on digit 0.
      applyStimulus(16'hABCD, 4'b0001, 4'b0100, 1'b1, 3 * FRAME);

      // Asynchronous reset in the middle of digit 2's slot.
      waitFrame(2 * FRAME);
      repeat (2 * CLK_DIV + 3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput('0, "async_reset");
      bus.iDATA  = 16'h5A0F;
      bus.iDP    = 4'b0010;
      bus.iBLANK = 4'b0000;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      waitFrame(4);
      repeat (2 * FRAME) @(negedge clk);

      // Leading-zero pattern (suppressed only with the macro defined).
      applyStimulus(16'h0050, 4'b1000, 4'b0000, 1'b1, 3 * FRAME);

      // Randomised data, blanks, dps and load requests.
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 19) == 0) begin
            bus.iDATA  = 16'($urandom);
            bus.iDP    = 4'($urandom);
            bus.iBLANK = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
         end
         if ($urandom_range(0, 29) == 0 && $urandom_range(0, 1) == 0)
            bus.iDATA = {8'h00, bus.iDATA[7:0]};
         bus.iLOAD = ($urandom_range(0, 39) == 0);
      end
      bus.iLOAD = 1'b0;
      repeat (FRAME) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
